// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write port, as seen by the arbiter (slave)
// and by whatever drives the producers and the FIFO full flag (master).
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = fifo_arb_pkg::id_width(N_REQ)
) ();

    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   fifo_full_i;
    logic                   fifo_wr_en_o;
    logic [WIDTH-1:0]       fifo_data_o;
    logic [ID_W-1:0]        grant_id_o;
    logic                   grant_active_o;

    modport slave (
        input  req_valid_i, req_data_i, fifo_full_i,
        output req_ready_o, fifo_wr_en_o, fifo_data_o, grant_id_o, grant_active_o
    );

    modport master (
        output req_valid_i, req_data_i, fifo_full_i,
        input  req_ready_o, fifo_wr_en_o, fifo_data_o, grant_id_o, grant_active_o
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning upward from
// last_ptr+1 with wrap-around.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_ptr_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             any_valid_o
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest candidate down so the nearest one is written last.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_ptr_i) + i) % N_REQ);
            if (req_i[idx]) begin
                winner_o    = idx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between N_REQ
// valid/ready producers, with bounded bursts and no pushes into a full FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic [ID_W-1:0]  sel;
    logic [N_REQ-1:0] ready;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i       (bus.req_valid_i),
        .last_ptr_i  (last_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        ready      = '0;
        sel        = owner_q;

        unique case (state_q)
            IDLE: begin
                sel = winner;
                if (any_valid && !bus.fifo_full_i) begin
                    ready[winner] = 1'b1;
                    owner_d       = winner;
                    if (MAX_BURST == 1) begin
                        last_ptr_d = winner;
                    end else begin
                        state_d    = BURST;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                ready[owner_q] = !bus.fifo_full_i;
                // A dropped valid ends the burst; the cycle spent noticing it is the bubble.
                if (!bus.req_valid_i[owner_q]) begin
                    state_d    = IDLE;
                    last_ptr_d = owner_q;
                    beat_cnt_d = '0;
                end else if (!bus.fifo_full_i) begin
                    if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        last_ptr_d = owner_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (rst_i) begin
            ready = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= ID_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.req_ready_o    = ready;
    assign bus.fifo_wr_en_o   = |(bus.req_valid_i & ready);
    assign bus.fifo_data_o    = bus.req_data_i[sel*WIDTH +: WIDTH];
    assign bus.grant_active_o = (state_q == BURST);
    assign bus.grant_id_o     = (state_q == BURST) ? owner_q : '0;

endmodule
